// File: rtl/ldm_stm_sequencer_if.sv
// ldm_stm_sequencer_if
//   Bundles the decode handshake, register-file ports and data-memory port
//   of the multi-register transfer sequencer.
//   master : the sequencer (drives regfile selects/write port, memory port,
//            busy/done/align_err).
//   slave  : the surrounding core (decode, register file, memory).
//   clk/rst are plain ports on the sequencer and not part of this bundle.
interface ldm_stm_sequencer_if #(parameter int ADDR_W = 32);
  // decode side
  logic              start;
  logic              is_load;
  logic [7:0]        reg_list;
  logic              extra_en;
  logic              descending;
  logic              writeback;
  logic [3:0]        base_sel;
  // register file
  logic [ADDR_W-1:0] base_val;
  logic [ADDR_W-1:0] store_data;
  logic [3:0]        regA_select;
  logic [3:0]        regB_select;
  logic [3:0]        write_dest;
  logic              write_en;
  logic [ADDR_W-1:0] write_data;
  // memory port
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  // status
  logic              busy;
  logic              done;
  logic              align_err;

  modport master (
    input  start, is_load, reg_list, extra_en, descending, writeback, base_sel,
           base_val, store_data, mem_ready, mem_rdata,
    output regA_select, regB_select, write_dest, write_en, write_data,
           mem_req, mem_we, mem_addr, mem_wdata, busy, done, align_err
  );

  modport slave (
    output start, is_load, reg_list, extra_en, descending, writeback, base_sel,
           base_val, store_data, mem_ready, mem_rdata,
    input  regA_select, regB_select, write_dest, write_en, write_data,
           mem_req, mem_we, mem_addr, mem_wdata, busy, done, align_err
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer
//   Expands one PUSH/POP/LDMIA/STMIA into single-word memory beats, driving
//   the register-file read selects, write port and base writeback.
//   Ports: clk, rst (async, active high), bus (ldm_stm_sequencer_if.master).
//   FSM: IDLE -> ADDR (sample base) -> XFER (one beat per register) -> WB.
//   Optional macro LSM_ALIGN_TRAP_EN: a misaligned base pulses align_err in
//   ADDR and aborts with no beats, no writes and no done. Without it
//   align_err is 0 and the memory address has bits [1:0] forced to 0.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst,
  ldm_stm_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, XFER, WB} state_t;
  state_t state, state_nxt;

  logic              is_load_q, extra_q, desc_q, wb_q;
  logic [7:0]        list_q, list_orig_q;
  logic [3:0]        base_sel_q;
  logic [ADDR_W-1:0] addr_q, final_q;

  logic [5:0]        n_regs;
  logic [ADDR_W-1:0] span, start_addr, final_base, addr_out;
  logic [2:0]        low_idx;
  logic [7:0]        list_clr;
  logic [3:0]        cur_reg;
  logic              last_beat, misaligned, wb_ok;

  // Transfer count: only meaningful in ADDR, before any bit is consumed.
  always_comb begin
    n_regs = {5'd0, extra_q};
    for (int i = 0; i < 8; i++) n_regs = n_regs + {5'd0, list_q[i]};
  end

  assign span       = {{(ADDR_W-8){1'b0}}, n_regs, 2'b00};
  assign start_addr = desc_q ? bus.base_val - span : bus.base_val;
  assign final_base = desc_q ? bus.base_val - span : bus.base_val + span;

  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (list_q[i]) low_idx = 3'(i);
  end

  assign list_clr  = list_q & (list_q - 8'd1);   // drop lowest set bit
  // The extra register (PC on load, LR on store) always goes last.
  assign cur_reg   = (list_q != 8'd0) ? {1'b0, low_idx}
                                      : (is_load_q ? 4'b1001 : 4'b1010);
  assign last_beat = (list_q == 8'd0) || (list_clr == 8'd0 && !extra_q);
  // A load that overwrites its own base keeps the loaded value.
  assign wb_ok = wb_q && !(is_load_q && !base_sel_q[3] && list_orig_q[base_sel_q[2:0]]);

`ifdef LSM_ALIGN_TRAP_EN
  assign misaligned = |bus.base_val[1:0];
  assign addr_out   = addr_q;                     // trapped bases never get here
`else
  assign misaligned = 1'b0;
  assign addr_out   = {addr_q[ADDR_W-1:2], 2'b00};
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = ADDR;
      ADDR: if (misaligned)          state_nxt = IDLE;
            else if (n_regs == 6'd0) state_nxt = WB;
            else                     state_nxt = XFER;
      XFER: if (bus.mem_ready && last_beat) state_nxt = WB;
      WB:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_load_q   <= 1'b0;
      extra_q     <= 1'b0;
      desc_q      <= 1'b0;
      wb_q        <= 1'b0;
      list_q      <= '0;
      list_orig_q <= '0;
      base_sel_q  <= '0;
      addr_q      <= '0;
      final_q     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          is_load_q   <= bus.is_load;
          extra_q     <= bus.extra_en;
          desc_q      <= bus.descending;
          wb_q        <= bus.writeback;
          list_q      <= bus.reg_list;
          list_orig_q <= bus.reg_list;
          base_sel_q  <= bus.base_sel;
        end
        ADDR: begin
          addr_q  <= start_addr;
          final_q <= final_base;
        end
        XFER: if (bus.mem_ready) begin
          addr_q <= addr_q + ADDR_W'(4);
          if (list_q != 8'd0) list_q  <= list_clr;
          else                extra_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // outputs: purely from state so reset clears them asynchronously
  always_comb begin
    bus.regA_select = 4'd0;
    bus.regB_select = 4'd0;
    bus.write_dest  = 4'd0;
    bus.write_en    = 1'b0;
    bus.write_data  = '0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.align_err   = 1'b0;
    case (state)
      ADDR: begin
        bus.busy        = 1'b1;
        bus.regA_select = base_sel_q;
        bus.align_err   = misaligned;
      end
      XFER: begin
        bus.busy     = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_out;
        if (!is_load_q) begin
          bus.mem_we      = 1'b1;
          bus.regB_select = cur_reg;
          bus.mem_wdata   = bus.store_data;
        end else if (bus.mem_ready) begin
          bus.write_en   = 1'b1;
          bus.write_dest = cur_reg;
          bus.write_data = bus.mem_rdata;
        end
      end
      WB: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        if (wb_ok) begin
          bus.write_en   = 1'b1;
          bus.write_dest = base_sel_q;
          bus.write_data = final_q;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: the driver predicts the full event
// stream of each operation (beats, register writes, done/align) from the
// instruction semantics and queues it; the monitor pops and compares.
module tb_ldm_stm_sequencer;
  localparam int K_BEAT = 0, K_WR = 1, K_DONE = 2, K_ALIGN = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  dest;
    logic        we;
    int          lat;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ldm_stm_sequencer_if bus();
  ldm_stm_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] rf [16];
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  always_comb bus.base_val   = rf[bus.regA_select];
  always_comb bus.store_data = rf[bus.regB_select];
  always_comb bus.mem_rdata  = mem_rd(bus.mem_addr);

  ev_t exp_q[$];
  int  checks = 0, failures = 0;
  int  cyc = 0, waits = 0, beats_seen = 0, ends_cnt = 0;
  int  beat_base = 0, stall_beat = -1, stall_n = 0, op_id = 0;
  bit  rnd_waits = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic ev_t mk(input int k, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] r, input logic w, input int l);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.dest = r; e.we = w; e.lat = l;
    return e;
  endfunction

  // Reference model: list of registers in order, addresses from base and count.
  task automatic predict(input bit ld, input logic [7:0] lst, input bit ext, input bit ds,
                         input bit wbk, input logic [3:0] bs, input logic [31:0] base);
    logic [3:0]  regs[$];
    logic [31:0] sa, fb, a;
    int n;
`ifdef LSM_ALIGN_TRAP_EN
    if (base[1:0] != 2'b00) begin
      exp_q.push_back(mk(K_ALIGN, 0, 0, 0, 0, 0));
      return;
    end
`endif
    for (int i = 0; i < 8; i++) if (lst[i]) regs.push_back(4'(i));
    if (ext) regs.push_back(ld ? 4'h9 : 4'hA);
    n  = regs.size();
    sa = ds ? base - 32'(4 * n) : base;
    fb = ds ? base - 32'(4 * n) : base + 32'(4 * n);
    for (int k = 0; k < n; k++) begin
      a = (sa + 32'(4 * k)) & ~32'h3;
      if (ld) begin
        exp_q.push_back(mk(K_BEAT, a, 0, 0, 1'b0, 0));
        exp_q.push_back(mk(K_WR, 0, mem_rd(a), regs[k], 1'b0, 0));
      end else begin
        exp_q.push_back(mk(K_BEAT, a, rf[regs[k]], 0, 1'b1, 0));
      end
    end
    if (wbk && !(ld && !bs[3] && lst[bs[2:0]]))
      exp_q.push_back(mk(K_WR, 0, fb, bs, 1'b0, 0));
    exp_q.push_back(mk(K_DONE, 0, 0, 0, 1'b0, 2 + n));
  endtask

  task automatic take(input int k, input string nm, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = mk(-1, 0, 0, 0, 0, 0);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got unexpected event, expected none", nm);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k) begin
        failures++;
        $display("FAIL %s: got event kind %0d expected kind %0d", nm, k, e.kind);
      end else ok = 1'b1;
    end
  endtask

  // Monitor: samples on the falling edge.
  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (rst) begin
      cyc = 0; waits = 0;
    end else begin
      if (bus.busy) cyc++;
      if (bus.mem_req) begin
        if (bus.mem_ready) begin
          take(K_BEAT, "beat", e, ok);
          if (ok) begin
            chk("beat_addr", bus.mem_addr, e.addr);
            chk("beat_we", {31'd0, bus.mem_we}, {31'd0, e.we});
            if (e.we) chk("beat_wdata", bus.mem_wdata, e.data);
          end
          beats_seen++;
        end else begin
          waits++;
          if (exp_q.size() > 0) begin
            chk("hold_addr", bus.mem_addr, exp_q[0].addr);
            chk("hold_we", {31'd0, bus.mem_we}, {31'd0, exp_q[0].we});
            if (exp_q[0].we) chk("hold_wdata", bus.mem_wdata, exp_q[0].data);
          end
        end
      end
      if (bus.write_en) begin
        take(K_WR, "write", e, ok);
        if (ok) begin
          chk("write_dest", {28'd0, bus.write_dest}, {28'd0, e.dest});
          chk("write_data", bus.write_data, e.data);
        end
      end
      if (bus.done) begin
        take(K_DONE, "done", e, ok);
        if (ok) chk("latency", cyc, 32'(e.lat + waits));
        cyc = 0; waits = 0; ends_cnt++;
      end
      if (bus.align_err) begin
        take(K_ALIGN, "align", e, ok);
        cyc = 0; waits = 0; ends_cnt++;
      end
    end
  end

  // Memory ready generator: optional stall window on a given beat, else random.
  initial begin
    int seen_id, given;
    seen_id = 0; given = 0;
    bus.mem_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (op_id != seen_id) begin seen_id = op_id; given = 0; end
      if (bus.mem_req && (beats_seen - beat_base) == stall_beat && given < stall_n) begin
        bus.mem_ready = 1'b0;
        given++;
      end else if (rnd_waits) bus.mem_ready = ($urandom_range(0, 3) != 0);
      else bus.mem_ready = 1'b1;
    end
  end

  task automatic drive(input bit ld, input logic [7:0] lst, input bit ext, input bit ds,
                       input bit wbk, input logic [3:0] bs);
    bus.is_load = ld; bus.reg_list = lst; bus.extra_en = ext;
    bus.descending = ds; bus.writeback = wbk; bus.base_sel = bs;
  endtask

  task automatic run_op(input bit ld, input logic [7:0] lst, input bit ext, input bit ds,
                        input bit wbk, input logic [3:0] bs, input logic [31:0] base,
                        input int sb, input int sn, input bit rw, input bit poke);
    int ends0;
    rf[bs] = base;
    predict(ld, lst, ext, ds, wbk, bs, base);
    beat_base = beats_seen; stall_beat = sb; stall_n = sn; rnd_waits = rw; op_id++;
    ends0 = ends_cnt;
    drive(ld, lst, ext, ds, wbk, bs);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (poke) begin
      @(posedge clk); #1;
      chk("busy_at_poke", {31'd0, bus.busy}, 32'd1);
      drive(~ld, 8'hFF, 1'b1, ~ds, 1'b1, 4'd7);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    for (int t = 0; t < 300 && ends_cnt == ends0; t++) @(posedge clk);
    #1;
    if (ends_cnt == ends0) begin
      chk("op_timeout", 32'd1, 32'd0);
      exp_q.delete();
      rst = 1'b1; #2; rst = 1'b0;
    end
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    rst = 1'b1;
    #2;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_write_en", {31'd0, bus.write_en}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_selects", {24'd0, bus.regA_select, bus.regB_select}, 32'd0);
    chk("rst_align", {31'd0, bus.align_err}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // PUSH {R0,R2,LR}, SP=0x100
    run_op(1'b0, 8'b0000_0101, 1'b1, 1'b1, 1'b1, 4'd8, 32'h100, -1, 0, 1'b0, 1'b0);
    // POP {R1,PC}, SP=0xF8
    mem[32'hF8] = 32'hAA; mem[32'hFC] = 32'hBB;
    run_op(1'b1, 8'b0000_0010, 1'b1, 1'b0, 1'b1, 4'd8, 32'hF8, -1, 0, 1'b0, 1'b0);
    // LDMIA R3!,{R3,R4}: base writeback suppressed
    run_op(1'b1, 8'b0001_1000, 1'b0, 1'b0, 1'b1, 4'd3, 32'h200, -1, 0, 1'b0, 1'b0);
    // STMIA with 3-cycle stall on second beat, plus a start while busy
    run_op(1'b0, 8'b0010_0001, 1'b0, 1'b0, 1'b1, 4'd2, 32'h300, 1, 3, 1'b0, 1'b1);
    // empty list with writeback
    run_op(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd8, 32'h40, -1, 0, 1'b0, 1'b0);

    // reset while stalled in XFER
    rf[8] = 32'h500;
    predict(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 4'd8, 32'h500);
    beat_base = beats_seen; stall_beat = 0; stall_n = 1000; rnd_waits = 1'b0; op_id++;
    drive(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 4'd8);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("pre_rst_mem_req", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    exp_q.delete();
    stall_n = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(1'b1, 8'b1000_0001, 1'b0, 1'b0, 1'b1, 4'd8, 32'h600, -1, 0, 1'b0, 1'b0);

    // unaligned base: trap when enabled, masked addresses otherwise
    run_op(1'b0, 8'b0000_0011, 1'b0, 1'b1, 1'b1, 4'd8, 32'h102, -1, 0, 1'b0, 1'b0);

    // randomized operations with random wait states
    for (int n = 0; n < 40; n++) begin
      logic [31:0] base;
      logic [7:0]  lst;
      for (int i = 0; i < 16; i++) rf[i] = $urandom;
      base = $urandom;
      if ($urandom_range(0, 7) != 0) base[1:0] = 2'b00;
      lst = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      run_op(1'($urandom), lst, 1'($urandom), 1'($urandom), 1'($urandom),
             4'($urandom), base, -1, 0, 1'b1, 1'b0);
    end

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
